// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: stream/config sequencer for fir_accel; define FIR_STREAM_CTRL_PERF_EN for perf counters.
module fir_stream_ctrl #(
    parameter int WIDTH     = 32,
    parameter int TAPS      = 8,
    parameter int AW        = $clog2(TAPS),
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic             fir_start,
    output logic [WIDTH-1:0] fir_sample_in,
    input  logic             fir_done,
    input  logic [WIDTH-1:0] fir_sample_out,
    output logic             fir_coeff_wr_en,
    output logic [AW-1:0]    fir_coeff_wr_addr,
    output logic [WIDTH-1:0] fir_coeff_wr_data,
    output logic             busy,
    output logic             err_timeout
`ifdef FIR_STREAM_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_samples,
    output logic [15:0]      perf_max_lat
`endif
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE = 3'd0, COEFF = 3'd1, ISSUE = 3'd2, ARM = 3'd3, WAIT = 3'd4, CAPTURE = 3'd5;

    logic [2:0]       state, state_nx;
    logic [WIDTH-1:0] in_mem  [IN_DEPTH];
    logic [WIDTH-1:0] out_mem [OUT_DEPTH];
    logic [IAW:0]     in_wp, in_rp;
    logic [OAW:0]     out_wp, out_rp;
    logic [TW-1:0]    wait_cnt;
    logic             live, in_full, in_empty, out_full, out_empty;
    logic             in_push, out_pop, go_cfg, go_issue, timed_out;

    assign in_empty  = in_wp == in_rp;
    assign in_full   = (in_wp ^ in_rp) == {1'b1, {IAW{1'b0}}};
    assign out_empty = out_wp == out_rp;
    assign out_full  = (out_wp ^ out_rp) == {1'b1, {OAW{1'b0}}};

    // live holds s_ready low until the first cycle after reset is released
    assign s_ready         = live && !in_full;
    assign in_push         = s_valid && s_ready;
    assign m_valid         = !out_empty;
    assign out_pop         = m_valid && m_ready;
    assign m_data          = m_valid ? out_mem[out_rp[OAW-1:0]] : '0;
    assign cfg_ready       = state == COEFF;
    assign fir_coeff_wr_en = state == COEFF;
    assign fir_start       = state == ISSUE;
    assign busy            = state != IDLE || !in_empty;

    // a free output slot is reserved at issue so CAPTURE can always push
    assign go_cfg    = state == IDLE && cfg_valid;
    assign go_issue  = state == IDLE && !cfg_valid && !in_empty && !out_full;
    assign timed_out = !fir_done && wait_cnt == TW'(TIMEOUT - 1);

    always_comb begin
        state_nx = go_cfg ? COEFF :
                   go_issue ? ISSUE :
                   state == ISSUE ? ARM :
                   state == ARM ? WAIT :
                   state == WAIT ? (fir_done ? CAPTURE : timed_out ? IDLE : WAIT) :
                   IDLE;
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp[IAW-1:0]] <= s_data;
        if (state == CAPTURE) out_mem[out_wp[OAW-1:0]] <= fir_sample_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            in_wp             <= '0;
            in_rp             <= '0;
            out_wp            <= '0;
            out_rp            <= '0;
            wait_cnt          <= '0;
            live              <= 1'b0;
            err_timeout       <= 1'b0;
            fir_sample_in     <= '0;
            fir_coeff_wr_addr <= '0;
            fir_coeff_wr_data <= '0;
        end else begin
            live     <= 1'b1;
            state    <= state_nx;
            wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
            if (in_push) in_wp <= in_wp + 1'b1;
            if (state == ISSUE) in_rp <= in_rp + 1'b1;
            if (state == CAPTURE) out_wp <= out_wp + 1'b1;
            if (out_pop) out_rp <= out_rp + 1'b1;
            if (go_cfg) begin
                fir_coeff_wr_addr <= cfg_addr;
                fir_coeff_wr_data <= cfg_data;
            end
            if (go_issue) fir_sample_in <= in_mem[in_rp[IAW-1:0]];
            if (state == WAIT && timed_out) err_timeout <= 1'b1;
        end
    end

`ifdef FIR_STREAM_CTRL_PERF_EN
    logic [15:0] lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat          <= '0;
            perf_samples <= '0;
            perf_max_lat <= '0;
        end else begin
            lat <= state == ISSUE ? 16'd1 : (lat != 16'hFFFF ? lat + 16'd1 : lat);
            if (state == CAPTURE) begin
                perf_samples <= perf_samples + 32'd1;
                if (lat > perf_max_lat) perf_max_lat <= lat;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: randomized bench with a behavioural 8-tap FIR attached and a sample-history scoreboard.
module tb_fir_stream_ctrl;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid, m_ready = 1'b0;
    logic [31:0] m_data;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        fir_start, fir_done = 1'b0;
    logic [31:0] fir_sample_in, fir_sample_out = '0;
    logic        fir_coeff_wr_en;
    logic [2:0]  fir_coeff_wr_addr;
    logic [31:0] fir_coeff_wr_data;
    logic        busy, err_timeout;
`ifdef FIR_STREAM_CTRL_PERF_EN
    logic [31:0] perf_samples;
    logic [15:0] perf_max_lat;
`endif

    fir_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fir_start(fir_start), .fir_sample_in(fir_sample_in),
        .fir_done(fir_done), .fir_sample_out(fir_sample_out),
        .fir_coeff_wr_en(fir_coeff_wr_en), .fir_coeff_wr_addr(fir_coeff_wr_addr),
        .fir_coeff_wr_data(fir_coeff_wr_data),
        .busy(busy), .err_timeout(err_timeout)
`ifdef FIR_STREAM_CTRL_PERF_EN
        , .perf_samples(perf_samples), .perf_max_lat(perf_max_lat)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, mr_mode = 1;
    int cfg_cyc = 0, start_cyc = 0;
    logic stuck = 1'b0;
    int coef_sh [8] = '{default: 0};
    int issued[$], pend_q[$], exp_q[$], got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // expected result: dot product of the coefficients with the last 8 issued samples
    function automatic int exp_dot();
        int acc = 0;
        for (int i = 0; i < 8; i++)
            if (i < issued.size()) acc += coef_sh[i] * issued[issued.size() - 1 - i];
        return acc;
    endfunction

    // fir_accel stand-in: random latency, done held until next start, stuck mode never finishes
    int f_hist [8] = '{default: 0};
    int f_coef [8] = '{default: 0};
    int f_res = 0, f_cd = 0;

    function automatic int fir_dot(input int x);
        int acc = x * f_coef[0];
        for (int i = 1; i < 8; i++) acc += f_hist[i-1] * f_coef[i];
        return acc;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fir_coeff_wr_en) f_coef[fir_coeff_wr_addr] <= fir_coeff_wr_data;
        if (fir_start) begin
            for (int i = 7; i > 0; i--) f_hist[i] <= f_hist[i-1];
            f_hist[0] <= fir_sample_in;
            f_res    <= fir_dot(fir_sample_in);
            f_cd     <= $urandom_range(1, 5);
            fir_done <= 1'b0;
        end else if (f_cd != 0) begin
            f_cd <= f_cd - 1;
            if (f_cd == 1 && !stuck) begin
                fir_done       <= 1'b1;
                fir_sample_out <= f_res;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = mr_mode == 2 ? 1'($urandom_range(0, 1)) : mr_mode == 1;
    end

    logic prev_start = 1'b0, hold = 1'b0;
    logic [31:0] hold_data = '0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (s_valid && s_ready) pend_q.push_back(s_data);
            if (cfg_valid && cfg_ready) begin
                coef_sh[cfg_addr] = cfg_data;
                cfg_cyc = cyc;
            end
            if (fir_coeff_wr_en) check("wr_in_flight", f_cd, 0);
            if (fir_start) begin
                check("start_width", prev_start, 0);
                check("issue_pending", pend_q.size() > 0, 1);
                if (pend_q.size() > 0) begin
                    check("sample_in", fir_sample_in, pend_q[0]);
                    issued.push_back(pend_q.pop_front());
                    if (!stuck) exp_q.push_back(exp_dot());
                end
                start_cyc = cyc;
            end
            if (hold) check("m_stable", m_data, hold_data);
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                if (exp_q.size() == 0) check("spurious_out", m_valid, 0);
                else check("m_data", m_data, exp_q.pop_front());
            end
            hold = m_valid && !m_ready;
            hold_data = m_data;
        end
        prev_start = fir_start;
    end

    task automatic push(input int v);
        int n = 0;
        s_valid = 1'b1;
        s_data = v;
        @(negedge clk);
        while (!s_ready && n < 500) begin @(negedge clk); n++; end
        check("push_ready", s_ready, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = d;
        @(negedge clk);
        while (!cfg_ready && n < 100) begin @(negedge clk); n++; end
        check("cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || m_valid || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        check("drain_busy", busy, 0);
        check("drain_lost", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!fir_start && n < 100) begin @(negedge clk); n++; end
        check("start_seen", fir_start, 1);
    endtask

    int load_v [4] = '{100, 200, 300, 400};
    int load_e [4] = '{100, 300, 600, 1000};
    int rel_v  [4] = '{10, 20, 30, 40};
    int rel_e  [4] = '{1010, 1030, 1060, 1100};
    int t0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_start", fir_start, 0);
        check("rst_err", err_timeout, 0);
        check("rst_wr_en", fir_coeff_wr_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) cfg_write(i, i < 4 ? 1 : 0);
        got_q.delete();
        foreach (load_v[i]) push(load_v[i]);
        wait_idle();
        check("load_n", got_q.size(), 4);
        foreach (load_e[i]) check("load_val", got_q[i], load_e[i]);

        for (int i = 0; i < 8; i++) cfg_write(i, 1);
        got_q.delete();
        foreach (rel_v[i]) push(rel_v[i]);
        wait_idle();
        check("reload_n", got_q.size(), 4);
        foreach (rel_e[i]) check("reload_val", got_q[i], rel_e[i]);

        mr_mode = 0;
        @(posedge clk);
        #1;
        got_q.delete();
        for (int i = 1; i <= 8; i++) push(i * 11);
        repeat (40) @(negedge clk);
        check("bp_s_ready", s_ready, 0);
        check("bp_m_valid", m_valid, 1);
        check("bp_busy", busy, 1);
        check("bp_none_out", got_q.size(), 0);
        @(posedge clk);
        #1 mr_mode = 1;
        wait_idle();
        check("bp_n", got_q.size(), 8);

        fork
            cfg_write(0, 7);
            push(3);
        join
        wait_idle();
        check("coll_order", cfg_cyc < start_cyc, 1);
        check("coll_coef", coef_sh[0], 7);

        mr_mode = 2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) cfg_write(i, int'($urandom_range(0, 100)) - 50);
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                push(int'($urandom_range(0, 2000)) - 1000);
            end
            wait_idle();
        end
        mr_mode = 1;

        stuck = 1'b1;
        got_q.delete();
        push(5);
        wait_start();
        t0 = cyc;
        for (int n = 0; n < 300 && !err_timeout; n++) @(negedge clk);
        check("to_err", err_timeout, 1);
        check("to_lat", (cyc - t0 >= TIMEOUT + 1) && (cyc - t0 <= TIMEOUT + 3), 1);
        check("to_m_valid", m_valid, 0);
        check("to_busy", busy, 0);
        repeat (100) @(negedge clk);
        check("to_sticky", err_timeout, 1);
        check("to_no_out", got_q.size(), 0);
        @(posedge clk);
        #1;

        push(9);
        wait_start();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_err", err_timeout, 0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_busy", busy, 0);
        stuck = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_rst_no_out", got_q.size(), 0);
        @(posedge clk);
        #1;
        push(11);
        wait_idle();
        check("post_abort_n", got_q.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
        $fatal(1);
    end
endmodule
